// File: rtl/jls_pipeline_sequencer.sv
// Issue/advance controller for the JPEG-LS encoder stage registers: per-stage enables,
// valid/context tracking, context-hazard bubbles, backpressure stall and frame drain/done.
`ifndef Q_length
`define Q_length 8
`endif

module jls_pipeline_sequencer #(
   parameter int NUM_STAGES = 6,
   parameter int HAZ_DEPTH  = 2,
   parameter int Q_length   = `Q_length,
   parameter int STALL_W    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   input  logic [Q_length-1:0]   pix_Q,
   input  logic                  pix_run,
   input  logic                  pix_EOF,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic                  stage_adv,
   output logic [NUM_STAGES-1:0] start_enc,
   output logic [NUM_STAGES-1:0] stage_valid,
   output logic                  busy,
   output logic                  done,
   output logic [STALL_W-1:0]    stall_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t                state;
   logic [NUM_STAGES-1:0] valid_q;
   logic [NUM_STAGES-1:0] run_q;
   logic [Q_length-1:0]   q_tag [NUM_STAGES];
   logic [NUM_STAGES-1:0] valid_next;
   logic                  haz_match;
   logic                  hazard;
   logic                  accept;
   logic                  state_open;

   assign out_valid   = valid_q[NUM_STAGES-1];
   assign stage_adv   = ~valid_q[NUM_STAGES-1] | out_ready;
   assign stage_valid = valid_q;
   assign busy        = (state != ST_IDLE);
   assign done        = (state == ST_DONE);

   // Only regular-mode pixels still in the first HAZ_DEPTH stages can conflict on a context.
   always_comb begin
      haz_match = 1'b0;
      for (int i = 0; i < HAZ_DEPTH; i++) begin
         if (valid_q[i] && !run_q[i] && (q_tag[i] == pix_Q)) begin
            haz_match = 1'b1;
         end
      end
   end

   assign hazard     = pix_valid & ~pix_run & haz_match;
   assign state_open = (state == ST_IDLE) | (state == ST_ACTIVE);
   assign pix_ready  = stage_adv & ~hazard & state_open & ~reset;
   assign accept     = pix_valid & pix_ready;

   assign valid_next = stage_adv ? {valid_q[NUM_STAGES-2:0], accept} : valid_q;
   assign start_enc  = stage_adv ? {valid_q[NUM_STAGES-2:0], accept} : '0;

   // Stage bookkeeping: the whole pipe shifts together; a hazard simply leaves a bubble in stage 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         run_q   <= '0;
         for (int i = 0; i < NUM_STAGES; i++) begin
            q_tag[i] <= '0;
         end
      end else if (stage_adv) begin
         valid_q  <= valid_next;
         run_q    <= {run_q[NUM_STAGES-2:0], pix_run};
         q_tag[0] <= pix_Q;
         for (int i = 1; i < NUM_STAGES; i++) begin
            q_tag[i] <= q_tag[i-1];
         end
      end
   end

   // Bubble counter restarts with each frame's first pixel and saturates instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if ((state == ST_IDLE) && accept) begin
         stall_cnt <= '0;
      end else if (hazard && stage_adv && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + {{(STALL_W-1){1'b0}}, 1'b1};
      end
   end

   // Frame sequencing: DRAIN closes intake until the pipe empties, DONE is a one-cycle marker.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state <= pix_EOF ? ST_DRAIN : ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (accept && pix_EOF) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (valid_next == '0) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jls_pipeline_sequencer.sv
// Self-checking bench for jls_pipeline_sequencer: directed frame scenarios plus random traffic,
// all compared each cycle against a pixel-level reference model.
module tb_jls_pipeline_sequencer;

   localparam int N  = 6;
   localparam int HZ = 2;
   localparam int QW = 4;
   localparam int SW = 16;

   localparam int MP_IDLE   = 0;
   localparam int MP_ACTIVE = 1;
   localparam int MP_DRAIN  = 2;
   localparam int MP_DONE   = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          pix_valid;
   logic          pix_ready;
   logic [QW-1:0] pix_Q;
   logic          pix_run;
   logic          pix_EOF;
   logic          out_ready;
   logic          out_valid;
   logic          stage_adv;
   logic [N-1:0]  start_enc;
   logic [N-1:0]  stage_valid;
   logic          busy;
   logic          done;
   logic [SW-1:0] stall_cnt;

   jls_pipeline_sequencer #(
      .NUM_STAGES(N),
      .HAZ_DEPTH (HZ),
      .Q_length  (QW),
      .STALL_W   (SW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_Q      (pix_Q),
      .pix_run    (pix_run),
      .pix_EOF    (pix_EOF),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .stage_adv  (stage_adv),
      .start_enc  (start_enc),
      .stage_valid(stage_valid),
      .busy       (busy),
      .done       (done),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   int num_checks = 0;
   int num_pass   = 0;
   int cyc        = 0;

   // Reference model: which pixel id sits in each stage (-1 = empty), plus per-pixel attributes.
   int slot [1:N];
   int pq_of [$];
   bit prun_of [$];
   int inflight;
   int phase;
   int stall_m;

   bit           last_acc;
   logic         obs_ready;
   logic         obs_adv;
   logic [N-1:0] obs_se;
   logic [SW-1:0] obs_stall;

   int acc_count, fire_count, done_count;
   int first_acc_cyc, first_ov_cyc, first_fire_cyc, last_fire_cyc, done_cyc;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      num_checks++;
      if (obs === exp) begin
         num_pass++;
      end else begin
         $display("[TB] FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic clear_trackers();
      acc_count      = 0;
      fire_count     = 0;
      done_count     = 0;
      first_acc_cyc  = -1;
      first_ov_cyc   = -1;
      first_fire_cyc = -1;
      last_fire_cyc  = -1;
      done_cyc       = -1;
   endtask

   task automatic model_reset();
      for (int i = 1; i <= N; i++) slot[i] = -1;
      inflight = 0;
      phase    = MP_IDLE;
      stall_m  = 0;
   endtask

   // One clock cycle: drive inputs, check every output against the model, then advance the model.
   task automatic applyStimulus(input bit pv, input int q, input bit run, input bit eof,
                                input bit ordy, input bit rst);
      bit           m_ov, m_adv, m_haz, m_rdy, m_acc;
      logic [N-1:0] m_sv, m_se;
      pix_valid = pv;
      pix_Q     = QW'(q);
      pix_run   = run;
      pix_EOF   = eof;
      out_ready = ordy;
      reset     = rst;
      #4;
      m_ov  = (slot[N] >= 0);
      m_adv = !m_ov || ordy;
      m_haz = 1'b0;
      if (pv && !run) begin
         for (int i = 1; i <= HZ; i++) begin
            if (slot[i] >= 0 && !prun_of[slot[i]] && pq_of[slot[i]] == q) m_haz = 1'b1;
         end
      end
      m_rdy = m_adv && !m_haz && (phase == MP_IDLE || phase == MP_ACTIVE) && !rst;
      m_acc = pv && m_rdy;
      for (int i = 1; i <= N; i++) m_sv[i-1] = (slot[i] >= 0);
      m_se[0] = m_acc;
      for (int i = 2; i <= N; i++) m_se[i-1] = m_adv && (slot[i-1] >= 0);

      obs_ready = pix_ready;
      obs_adv   = stage_adv;
      obs_se    = start_enc;
      obs_stall = stall_cnt;
      checkOutput("out_valid", out_valid, m_ov);
      checkOutput("stage_adv", stage_adv, m_adv);
      checkOutput("pix_ready", pix_ready, m_rdy);
      checkOutput("start_enc", start_enc, m_se);
      checkOutput("stage_valid", stage_valid, m_sv);
      checkOutput("busy", busy, phase != MP_IDLE);
      checkOutput("done", done, phase == MP_DONE);
      checkOutput("stall_cnt", stall_cnt, stall_m);

      if (m_acc) begin
         acc_count++;
         if (first_acc_cyc < 0) first_acc_cyc = cyc;
      end
      if (out_valid === 1'b1 && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (out_valid === 1'b1 && ordy) begin
         fire_count++;
         if (first_fire_cyc < 0) first_fire_cyc = cyc;
         last_fire_cyc = cyc;
      end
      if (done === 1'b1) begin
         done_count++;
         done_cyc = cyc;
      end
      last_acc = m_acc;

      @(posedge clk);
      cyc++;
      if (rst) begin
         model_reset();
      end else begin
         if (m_adv && m_ov) inflight--;
         if (phase == MP_IDLE && m_acc) stall_m = 0;
         else if (m_haz && m_adv && stall_m != 65535) stall_m++;
         if (m_adv) begin
            for (int i = N; i >= 2; i--) slot[i] = slot[i-1];
            slot[1] = -1;
            if (m_acc) begin
               pq_of.push_back(q);
               prun_of.push_back(run);
               slot[1] = pq_of.size() - 1;
               inflight++;
            end
         end
         case (phase)
            MP_IDLE:   if (m_acc) phase = eof ? MP_DRAIN : MP_ACTIVE;
            MP_ACTIVE: if (m_acc && eof) phase = MP_DRAIN;
            MP_DRAIN:  if (inflight == 0) phase = MP_DONE;
            default:   phase = MP_IDLE;
         endcase
      end
      #1;
   endtask

   task automatic feed(input int q, input bit run, input bit eof, input bit ordy, output int waited);
      waited   = 0;
      last_acc = 1'b0;
      while (!last_acc && waited < 40) begin
         applyStimulus(1'b1, q, run, eof, ordy, 1'b0);
         if (!last_acc) waited++;
      end
      checkOutput("feed_accepted", last_acc, 1);
   endtask

   task automatic wait_done(input int max_cycles);
      int n = 0;
      while (done_count == 0 && n < max_cycles) begin
         applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
         n++;
      end
      checkOutput("done_seen", done_count > 0, 1);
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog expired @cyc %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int w;
      reset = 1'b1; pix_valid = 1'b0; pix_Q = '0; pix_run = 1'b0; pix_EOF = 1'b0; out_ready = 1'b1;
      model_reset();
      clear_trackers();
      repeat (2) @(posedge clk);
      #1;
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);

      $display("[TB] test 1: ten regular pixels back to back");
      clear_trackers();
      for (int k = 0; k < 10; k++) feed(k, 1'b0, k == 9, 1'b1, w);
      wait_done(40);
      checkOutput("t1_latency", first_ov_cyc - (first_acc_cyc + 1), 5);
      checkOutput("t1_fires", fire_count, 10);
      checkOutput("t1_back_to_back", last_fire_cyc - first_fire_cyc, 9);
      checkOutput("t1_stall", stall_cnt, 0);
      checkOutput("t1_done_gap", done_cyc - last_fire_cyc, 1);

      $display("[TB] test 2: context hazard on repeated Q");
      clear_trackers();
      feed(5, 1'b0, 1'b0, 1'b1, w);
      feed(5, 1'b0, 1'b1, 1'b1, w);
      checkOutput("t2_hold", w, 2);
      wait_done(40);
      checkOutput("t2_stall", stall_cnt, 2);
      clear_trackers();
      feed(5, 1'b0, 1'b0, 1'b1, w);
      feed(5, 1'b1, 1'b1, 1'b1, w);
      checkOutput("t2_run_hold", w, 0);
      wait_done(40);
      checkOutput("t2_run_stall", stall_cnt, 0);

      $display("[TB] test 3: backpressure on a full pipe");
      clear_trackers();
      for (int k = 1; k <= 6; k++) feed(k, 1'b0, 1'b0, 1'b1, w);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 8, 1'b0, 1'b0, 1'b0, 1'b0);
         checkOutput("t3_adv", obs_adv, 0);
         checkOutput("t3_start_enc", obs_se, 0);
         checkOutput("t3_ready", obs_ready, 0);
      end
      feed(8, 1'b0, 1'b1, 1'b1, w);
      wait_done(40);
      checkOutput("t3_fires", fire_count, 7);
      checkOutput("t3_fires_vs_accepts", fire_count, acc_count);

      $display("[TB] test 4: end of frame drain");
      clear_trackers();
      for (int k = 1; k <= 4; k++) feed(k, 1'b0, k == 4, 1'b1, w);
      for (int k = 0; k < 30 && done_count == 0; k++) begin
         applyStimulus(1'b1, 10, 1'b0, 1'b0, 1'b1, 1'b0);
         checkOutput("t4_ready_closed", obs_ready, 0);
      end
      checkOutput("t4_done_gap", done_cyc - last_fire_cyc, 1);
      checkOutput("t4_fires", fire_count, 4);
      checkOutput("t4_busy", busy, 0);
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("t4_done_once", done_count, 1);

      $display("[TB] test 5: reset with pixels in flight");
      clear_trackers();
      feed(3, 1'b0, 1'b0, 1'b1, w);
      feed(3, 1'b0, 1'b0, 1'b1, w);
      feed(6, 1'b0, 1'b0, 1'b1, w);
      checkOutput("t5_pre_stall", stall_cnt, 2);
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("t5_stage_valid", stage_valid, 0);
      checkOutput("t5_busy", busy, 0);
      checkOutput("t5_stall", stall_cnt, 0);
      clear_trackers();
      repeat (10) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("t5_no_done", done_count, 0);

      $display("[TB] test 6: hazard during backpressure");
      clear_trackers();
      for (int k = 0; k < 5; k++) feed(k, 1'b0, 1'b0, 1'b1, w);
      feed(7, 1'b0, 1'b0, 1'b1, w);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b0);
         checkOutput("t6_adv", obs_adv, 0);
         checkOutput("t6_stall_frozen", obs_stall, 0);
      end
      feed(7, 1'b0, 1'b0, 1'b1, w);
      checkOutput("t6_hold", w, 2);
      checkOutput("t6_stall", stall_cnt, 2);
      feed(9, 1'b0, 1'b1, 1'b1, w);
      wait_done(40);

      $display("[TB] random traffic");
      clear_trackers();
      for (int k = 0; k < 600; k++) begin
         applyStimulus($urandom_range(0, 99) < 60, int'($urandom_range(0, 3)),
                       $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                       $urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
      end
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", num_pass, num_checks);
      $finish;
   end

endmodule
